// File: rtl/axis_probe_mc.sv
// AXI-Stream probe: H2C packets load per-channel DUT stimulus, C2H returns DUT results.
// Optional AXIS_PROBE_MC_SEQ_EN adds a 16-bit response sequence number.
module axis_probe_mc #(
  parameter int C_DATA_WIDTH      = 128,
  parameter int VIP2DUT_WORDS_NUM = 16,
  parameter int DUT2VIP_WORDS_NUM = 16,
  parameter int CH_NUM            = 4,
  parameter int SAMPLE_DELAY      = 2
)(
  input  logic                        s_axis_aclk,
  input  logic                        s_axis_areset,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                        s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic                        s_axis_bad_packet,
  output logic [CH_NUM*C_DATA_WIDTH*VIP2DUT_WORDS_NUM-1:0] vip2dut_bus,
  output logic [CH_NUM-1:0]           vip2dut_update,
  input  logic [CH_NUM*C_DATA_WIDTH*DUT2VIP_WORDS_NUM-1:0] dut2vip_bus
);
  localparam int W   = C_DATA_WIDTH;
  localparam int VB  = W * VIP2DUT_WORDS_NUM;
  localparam int DB  = W * DUT2VIP_WORDS_NUM;
  localparam int VCW = (VIP2DUT_WORDS_NUM > 1) ? $clog2(VIP2DUT_WORDS_NUM) : 1;
  localparam int DCW = (DUT2VIP_WORDS_NUM > 1) ? $clog2(DUT2VIP_WORDS_NUM) : 1;

  localparam logic [2:0] S_HDR       = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_DRAIN     = 3'd2;
  localparam logic [2:0] S_WAIT      = 3'd3;
  localparam logic [2:0] S_RESP_HDR  = 3'd4;
  localparam logic [2:0] S_RESP_DATA = 3'd5;

  localparam logic [7:0] OP_WR   = 8'h01;
  localparam logic [7:0] OP_WRRD = 8'h02;
  localparam logic [7:0] OP_RD   = 8'h03;

  logic [2:0]        state_q, state_d;
  logic [7:0]        ch_q, ch_d;
  logic [7:0]        op_q, op_d;
  logic [VCW-1:0]    wcnt_q, wcnt_d;
  logic [DCW-1:0]    rcnt_q, rcnt_d;
  logic [7:0]        dly_q, dly_d;
  logic [VB-1:0]     shd_q, shd_d;
  logic [DB-1:0]     rsp_q, rsp_d;
  logic [CH_NUM*VB-1:0] bus_q;
  logic [CH_NUM-1:0] upd_q, upd_d;
  logic              bad_q, bad_d;
  logic              commit;
  logic              s_hs, m_hs, last_beat, hbad;
  logic [7:0]        hch, hop;
  logic [15:0]       seq;
  logic              unused_keep;

  assign unused_keep = ^s_axis_tkeep;

  assign hch = s_axis_tdata[7:0];
  assign hop = s_axis_tdata[15:8];
  assign hbad = ({1'b0, hch} >= 9'(CH_NUM)) ||
                !(hop inside {OP_WR, OP_WRRD, OP_RD});

  assign s_axis_tready = !s_axis_areset &&
    (state_q == S_HDR || state_q == S_LOAD || state_q == S_DRAIN);
  assign s_hs = s_axis_tvalid && s_axis_tready;

  assign m_axis_tvalid = (state_q == S_RESP_HDR) || (state_q == S_RESP_DATA);
  assign m_hs = m_axis_tvalid && m_axis_tready;
  assign last_beat = (state_q == S_RESP_DATA) &&
                     (rcnt_q == DCW'(DUT2VIP_WORDS_NUM-1));
  assign m_axis_tlast = last_beat;
  assign m_axis_tkeep = '1;

  assign s_axis_bad_packet = bad_q;
  assign vip2dut_update    = upd_q;
  assign vip2dut_bus       = bus_q;

`ifdef AXIS_PROBE_MC_SEQ_EN
  logic [15:0] seq_q;
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) seq_q <= '0;
    else if (m_hs && last_beat) seq_q <= seq_q + 16'd1;
  end
  assign seq = seq_q;
`else
  assign seq = 16'h0;
`endif

  always_comb begin
    m_axis_tdata = '0;
    if (state_q == S_RESP_HDR) m_axis_tdata[31:0] = {seq, op_q, ch_q};
    else if (state_q == S_RESP_DATA) m_axis_tdata = rsp_q[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    op_d    = op_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    dly_d   = dly_q;
    shd_d   = shd_q;
    rsp_d   = rsp_q;
    upd_d   = '0;
    bad_d   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      S_HDR: if (s_hs) begin
        ch_d   = hch;
        op_d   = hop;
        wcnt_d = '0;
        dly_d  = '0;
        shd_d  = '0;
        if (hbad) begin
          bad_d   = 1'b1;
          state_d = s_axis_tlast ? S_HDR : S_DRAIN;
        end else if (hop == OP_RD) begin
          bad_d   = !s_axis_tlast;
          state_d = s_axis_tlast ? S_WAIT : S_DRAIN;
        end else if (s_axis_tlast) begin
          bad_d = 1'b1;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: if (s_hs) begin
        // Shift words in from the top so word 0 ends at the bottom.
        shd_d = shd_q >> W;
        shd_d[VB-1 -: W] = s_axis_tdata;
        if (wcnt_q == VCW'(VIP2DUT_WORDS_NUM-1)) begin
          if (s_axis_tlast) begin
            commit = 1'b1;
            for (int c = 0; c < CH_NUM; c++)
              upd_d[c] = (ch_q == 8'(c));
            state_d = (op_q == OP_WRRD) ? S_WAIT : S_HDR;
          end else begin
            bad_d   = 1'b1;
            state_d = S_DRAIN;
          end
        end else if (s_axis_tlast) begin
          bad_d   = 1'b1;
          state_d = S_HDR;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_DRAIN: if (s_hs && s_axis_tlast) state_d = S_HDR;
      S_WAIT: begin
        if (dly_q == 8'(SAMPLE_DELAY-1)) begin
          for (int c = 0; c < CH_NUM; c++)
            if (ch_q == 8'(c)) rsp_d = dut2vip_bus[c*DB +: DB];
          state_d = S_RESP_HDR;
        end else begin
          dly_d = dly_q + 8'd1;
        end
      end
      S_RESP_HDR: if (m_axis_tready) begin
        rcnt_d  = '0;
        state_d = S_RESP_DATA;
      end
      S_RESP_DATA: if (m_axis_tready) begin
        rsp_d = rsp_q >> W;
        if (last_beat) state_d = S_HDR;
        else rcnt_d = rcnt_q + 1'b1;
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state_q <= S_HDR;
      ch_q    <= '0;
      op_q    <= '0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      dly_q   <= '0;
      shd_q   <= '0;
      rsp_q   <= '0;
      bus_q   <= '0;
      upd_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      op_q    <= op_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      dly_q   <= dly_d;
      shd_q   <= shd_d;
      rsp_q   <= rsp_d;
      upd_q   <= upd_d;
      bad_q   <= bad_d;
      for (int c = 0; c < CH_NUM; c++)
        if (commit && ch_q == 8'(c)) bus_q[c*VB +: VB] <= shd_d;
    end
  end
endmodule

// File: tb/tb_axis_probe_mc.sv
// Directed and random packets against a packet-level model of the probe.
// Set AXIS_PROBE_MC_SEQ_EN on both files to model the sequence field.
module tb_axis_probe_mc;
  localparam int W  = 128;
  localparam int VW = 16;
  localparam int DW = 16;
  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [W-1:0] s_tdata = '0;
  logic [W/8-1:0] s_tkeep = '1;
  logic m_tvalid, m_tready = 1'b1, m_tlast;
  logic [W-1:0] m_tdata;
  logic [W/8-1:0] m_tkeep;
  logic bad;
  logic [CH*W*VW-1:0] v2d;
  logic [CH-1:0] upd;
  logic [CH*W*DW-1:0] d2v = '0;

  axis_probe_mc dut (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .s_axis_bad_packet(bad), .vip2dut_bus(v2d),
    .vip2dut_update(upd), .dut2vip_bus(d2v)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int m_mode = 0;
  logic [W-1:0] model_bus [CH][VW];
  logic [W-1:0] d2v_m [CH][DW];
  logic [15:0] seq_m = 16'h0;

  // Monitor observations, sampled on the falling edge.
  logic [CH-1:0] upd_log[$];
  logic [W-1:0] c2h_d[$];
  logic c2h_l[$];
  int bad_n = 0, s_n = 0, hold_err = 0;
  logic hold_v = 1'b0, hold_l;
  logic [W-1:0] hold_d;

  always @(negedge clk) begin
    if (rst) hold_v = 1'b0;
    else begin
      if (upd != '0) upd_log.push_back(upd);
      if (bad) bad_n++;
      if (s_tvalid && s_tready) s_n++;
      if (m_tvalid) begin
        if (hold_v && (m_tdata !== hold_d || m_tlast !== hold_l)) hold_err++;
        if (m_tkeep !== '1) hold_err++;
        if (m_tready) begin
          c2h_d.push_back(m_tdata);
          c2h_l.push_back(m_tlast);
        end
        hold_v = !m_tready;
        hold_d = m_tdata;
        hold_l = m_tlast;
      end else begin
        if (hold_v) hold_err++;
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (m_mode == 1) m_tready = ~m_tready;
      else if (m_mode == 2) m_tready = 1'($urandom_range(0, 1));
      else m_tready = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [W-1:0] d, input logic l);
    int n = 0;
    s_tdata = d;
    s_tlast = l;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 300) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    assert (s_tready === 1'b1) else begin
      miscompares++;
      $error("FAIL s_timeout obs=%b exp=1", s_tready);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic chk_bus(input string tag);
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < VW; k++)
        chk(tag, v2d[(c*VW+k)*W +: W], model_bus[c][k]);
  endtask

  task automatic clear_model();
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < VW; k++) model_bus[c][k] = '0;
    seq_m = 16'h0;
  endtask

  // One packet of L beats (header included), tlast on the final beat only.
  task automatic run_pkt(input int ch, input int op, input int L,
                         input int mode, input int pbase, input int dbase);
    logic [W-1:0] hdr, rh;
    logic [W-1:0] pay[$];
    bit hb, e_upd, e_rsp, e_bad;
    int b0, s0, n;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < DW; k++) begin
        d2v_m[c][k] = (dbase >= 0) ? W'(dbase + k) :
                      {$urandom, $urandom, $urandom, $urandom};
        d2v[(c*DW+k)*W +: W] = d2v_m[c][k];
      end
    hdr = {$urandom, $urandom, $urandom, $urandom};
    hdr[7:0] = ch[7:0];
    hdr[15:8] = op[7:0];
    for (int i = 0; i < L-1; i++)
      pay.push_back((pbase >= 0) ? W'(pbase + i) :
                    {$urandom, $urandom, $urandom, $urandom});
    hb = (ch >= CH) || (op < 1) || (op > 3);
    e_upd = !hb && (op == 1 || op == 2) && (L == VW + 1);
    e_rsp = !hb && ((op == 3 && L == 1) || (op == 2 && L == VW + 1));
    e_bad = !(e_upd || e_rsp);
    upd_log.delete();
    c2h_d.delete();
    c2h_l.delete();
    b0 = bad_n;
    s0 = s_n;
    m_mode = mode;
    beat(hdr, L == 1);
    for (int i = 0; i < L-1; i++) beat(pay[i], i == L-2);
    n = 0;
    while (e_rsp && c2h_d.size() < DW + 1 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
    if (e_upd)
      for (int k = 0; k < VW; k++) model_bus[ch][k] = pay[k];
    chk("bad_pulses", W'(bad_n - b0), W'(e_bad));
    chk("s_beats", W'(s_n - s0), W'(L));
    chk("upd_count", W'(upd_log.size()), W'(e_upd));
    if (e_upd && upd_log.size() > 0)
      chk("upd_value", W'(upd_log[0]), W'(1 << ch));
    chk_bus("vip2dut");
    chk("c2h_count", W'(c2h_d.size()), e_rsp ? W'(DW + 1) : W'(0));
    if (e_rsp && c2h_d.size() == DW + 1) begin
      rh = '0;
      rh[7:0] = ch[7:0];
      rh[15:8] = op[7:0];
      rh[31:16] = seq_m;
      chk("rsp_hdr", c2h_d[0], rh);
      chk("rsp_hdr_last", W'(c2h_l[0]), W'(0));
      for (int k = 0; k < DW; k++) begin
        chk("rsp_data", c2h_d[k+1], d2v_m[ch][k]);
        chk("rsp_last", W'(c2h_l[k+1]), W'(k == DW - 1));
      end
    end
`ifdef AXIS_PROBE_MC_SEQ_EN
    if (e_rsp) seq_m = seq_m + 16'd1;
`endif
    chk("stall_hold", W'(hold_err), W'(0));
  endtask

  task automatic chk_reset_outs();
    chk("rst_tready", W'(s_tready), W'(0));
    chk("rst_mvalid", W'(m_tvalid), W'(0));
    chk("rst_mlast", W'(m_tlast), W'(0));
    chk("rst_mdata", m_tdata, W'(0));
    chk("rst_bad", W'(bad), W'(0));
    chk("rst_upd", W'(upd), W'(0));
    chk_bus("rst_bus");
  endtask

  initial begin
    int ops[8] = '{1, 2, 3, 3, 2, 1, 0, 7};
    int op, ch, L;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs();
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_pkt(1, 1, VW + 1, 0, 'h100, -1);
    run_pkt(2, 3, 1, 1, -1, 'hA0);
    run_pkt(0, 2, 9, 0, -1, -1);
    run_pkt(0, 1, VW + 1, 0, -1, -1);
    run_pkt(9, 1, VW + 1, 0, -1, -1);
    run_pkt(3, 2, VW + 1, 2, -1, -1);
    run_pkt(1, 3, 3, 0, -1, -1);
    run_pkt(2, 1, VW + 3, 0, -1, -1);
    run_pkt(2, 2, 1, 0, -1, -1);

    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 7)];
      ch = $urandom_range(0, 4);
      if (op == 3) L = ($urandom_range(0, 3) == 0) ? 3 : 1;
      else if (op == 1 || op == 2)
        case ($urandom_range(0, 5))
          0: L = 1;
          1: L = $urandom_range(2, VW);
          2: L = VW + 2;
          default: L = VW + 1;
        endcase
      else L = $urandom_range(1, 5);
      run_pkt(ch, op, L, $urandom_range(0, 2), -1, -1);
    end

    // Reset during word 4 (fifth data beat) of a WRRD.
    m_mode = 0;
    beat({112'h0, 8'h02, 8'h03}, 1'b0);
    for (int i = 0; i < 4; i++) beat(W'(i + 'h55), 1'b0);
    s_tdata = W'('h77);
    s_tvalid = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    #1;
    chk_reset_outs();
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outs();
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_pkt(3, 1, VW + 1, 0, -1, -1);
    run_pkt(1, 3, 1, 2, -1, -1);
    run_pkt(0, 3, 1, 0, -1, -1);
    run_pkt(3, 3, 1, 1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
